// File: rtl/seq_pkg.sv
// seq_pkg: shared shifter state encoding and default serializer sizing
package seq_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
endpackage

// File: rtl/nibble_fifo.sv
// nibble_fifo: word buffer with wrapping pointers and an occupancy count
module nibble_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer: buffers parallel words and shifts them out one bit per enabled cycle
module nibble_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [0:0] state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] sreg, head, shifted;
    logic [$clog2(DEPTH):0] count;
    logic full, empty, pop;
    nibble_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(in_valid), .pop(pop), .din(in_data),
        .dout(head), .count(count), .full(full), .empty(empty)
    );
    assign in_ready  = !full;
    assign out_valid = state == SHIFT;
    assign out_last  = out_valid && cnt == LAST;
    assign out_bit   = out_valid && (MSB_FIRST != 0 ? sreg[WIDTH-1] : sreg[0]);
    assign busy      = out_valid || count != '0;
    assign shifted   = MSB_FIRST != 0 ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    // Reloading on the last consumed bit keeps back-to-back words gapless
    assign pop = !empty && (state == IDLE || (out_en && out_last));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else if (pop) begin
            state <= SHIFT;
            cnt   <= '0;
            sreg  <= head;
        end else if (out_valid && out_en) begin
            state <= out_last ? IDLE : SHIFT;
            cnt   <= out_last ? '0 : cnt + CW'(1);
            sreg  <= out_last ? '0 : shifted;
        end
    end
endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: directed checks of the serializer in both bit orders
module tb_nibble_serializer;
    logic clk = 0, rst = 0;
    logic [3:0] d0 = 0, d1 = 0;
    logic v0 = 0, v1 = 0, e0 = 1, e1 = 1;
    logic r0, r1, ob0, ob1, ov0, ov1, ol0, ol1, b0, b1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    nibble_serializer #(.WIDTH(4), .DEPTH(2), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .out_en(e0),
        .out_bit(ob0), .out_valid(ov0), .out_last(ol0), .busy(b0));
    nibble_serializer #(.WIDTH(4), .DEPTH(2), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .out_en(e1),
        .out_bit(ob1), .out_valid(ov1), .out_last(ol1), .busy(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_bits(input int sel, input string tag, input logic [15:0] bits,
                            input logic [15:0] lasts, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_v%0d", tag, i), sel != 0 ? ov1 : ov0, 1);
            chk($sformatf("%s_b%0d", tag, i), sel != 0 ? ob1 : ob0, bits[n-1-i]);
            chk($sformatf("%s_l%0d", tag, i), sel != 0 ? ol1 : ol0, lasts[n-1-i]);
            @(negedge clk);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle_v"}, ov0, 0);
        chk({tag, "_idle_b"}, ob0, 0);
        chk({tag, "_idle_busy"}, b0, 0);
        chk({tag, "_idle_rdy"}, r0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_v", ov0, 0); chk("rst_b", ob0, 0); chk("rst_l", ol0, 0);
        chk("rst_busy", b0, 0); chk("rst_rdy", r0, 1);
        // single word 0101, first bit two edges after acceptance
        rst = 1; d0 = 4'b0101; v0 = 1;
        @(negedge clk); v0 = 0;
        chk("lat_v", ov0, 0); chk("lat_busy", b0, 1);
        @(negedge clk);
        get_bits(0, "w0101", 16'b0101, 16'b0001, 4);
        chk_idle("t1");
        // back-to-back words, no gap
        d0 = 4'b0101; v0 = 1;
        @(negedge clk); d0 = 4'b0011;
        @(negedge clk); v0 = 0;
        get_bits(0, "b2b", 16'b0101_0011, 16'b0001_0001, 8);
        chk_idle("t2");
        // stalled output fills buffer; word offered while full is ignored
        e0 = 0; d0 = 4'b1001; v0 = 1;
        @(negedge clk); d0 = 4'b0110; chk("fill1_rdy", r0, 1);
        @(negedge clk); d0 = 4'b1100; chk("fill2_rdy", r0, 1);
        @(negedge clk); d0 = 4'b1111; chk("full_rdy", r0, 0);
        @(negedge clk); v0 = 0;
        chk("full_rdy2", r0, 0); chk("full_b", ob0, 1); chk("full_busy", b0, 1);
        e0 = 1;
        get_bits(0, "fill", 16'b1001_0110_1100, 16'b0001_0001_0001, 12);
        chk_idle("t3");
        // stall mid-word holds the current bit
        d0 = 4'b1010; v0 = 1;
        @(negedge clk); v0 = 0;
        @(negedge clk);
        get_bits(0, "st_a", 16'b1, 16'b0, 1);
        e0 = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_b%0d", i), ob0, 0);
            chk($sformatf("stall_v%0d", i), ov0, 1);
            chk($sformatf("stall_l%0d", i), ol0, 0);
            @(negedge clk);
        end
        e0 = 1;
        get_bits(0, "st_b", 16'b010, 16'b001, 3);
        chk_idle("t4");
        // reset mid-word with a buffered word pending
        d0 = 4'b1010; v0 = 1;
        @(negedge clk); d0 = 4'b0110;
        @(negedge clk); v0 = 0;
        get_bits(0, "pre_rst", 16'b10, 16'b00, 2);
        rst = 0; #1;
        chk("arst_v", ov0, 0); chk("arst_b", ob0, 0); chk("arst_l", ol0, 0);
        chk("arst_busy", b0, 0); chk("arst_rdy", r0, 1);
        @(negedge clk); rst = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_v%0d", i), ov0, 0);
            chk($sformatf("post_rst_busy%0d", i), b0, 0);
        end
        // LSB-first instance
        chk("lsb_rdy", r1, 1);
        d1 = 4'b0001; v1 = 1;
        @(negedge clk); v1 = 0; chk("lsb_busy", b1, 1);
        @(negedge clk);
        get_bits(1, "lsb", 16'b1000, 16'b0001, 4);
        chk("lsb_idle_v", ov1, 0); chk("lsb_idle_b", ob1, 0); chk("lsb_idle_busy", b1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter WIDTH, default 4, bits per input word.
REQ-002 Parameter DEPTH, default 2, word-buffer entries (power of two, >=2).
REQ-003 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 first.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  buffer can accept a word this cycle.
REQ-009 out_en  input  1  downstream consumes a bit this cycle; 0 = stall.
REQ-010 out_bit  output  1  serial data bit, feeds the 1-bit sequence-detector input.
REQ-011 out_valid  output  1  out_bit carries a real data bit.
REQ-012 out_last  output  1  out_bit is the final bit of its word.
REQ-013 busy  output  1  shifter active or buffer non-empty.

Function
REQ-014 Word accepted on a rising edge where in_valid=1 and in_ready=1; otherwise in_data ignored.
REQ-015 in_ready = (buffer count < DEPTH), combinational from registered count only; no dependence on in_valid.
REQ-016 Buffer is FIFO; words leave in acceptance order; no word dropped or duplicated.
REQ-017 Shifter FSM states: IDLE, SHIFT.
REQ-018 IDLE: out_valid=0; if buffer non-empty, pop head into shift register, bit counter=0, go SHIFT.
REQ-019 SHIFT: out_valid=1; out_bit = current bit per MSB_FIRST; on edge with out_en=1, counter increments and register shifts.
REQ-020 out_last=1 in SHIFT when counter=WIDTH-1.
REQ-021 On consuming last bit (out_en=1, counter=WIDTH-1): if buffer non-empty, load next word same edge, stay SHIFT (no bubble); else go IDLE.
REQ-022 out_en=0 in SHIFT: out_bit, out_valid, out_last, counter, shift register all hold.
REQ-023 Latency: word accepted into empty idle block at edge N -> its first bit on out_bit with out_valid=1 after edge N+2 (one edge to buffer, one to load).
REQ-024 Simultaneous push and pop same edge: both take effect; count unchanged; allowed when full (pop frees slot only next cycle, in_ready stays from registered count).
REQ-025 Buffer pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-026 out_bit=0 whenever out_valid=0.
REQ-027 busy = (state==SHIFT) or (count!=0).

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, count 0, pointers 0, counter 0, shift register 0.
REQ-029 During and after reset: out_bit=0, out_valid=0, out_last=0, busy=0, in_ready=1.
REQ-030 Reset mid-word discards the partial word and all buffered words; no bit of them emitted after release.
REQ-031 First acceptance possible on first rising edge with rst=1.

Structure
REQ-032 Shared package seq_pkg holds FSM state encoding (IDLE=0, SHIFT=1) and default WIDTH/DEPTH constants.
REQ-033 Buffer is sub-module nibble_fifo (push/pop/count/full/empty, parameters WIDTH, DEPTH); shifter FSM in top.

Verification
REQ-034 Reset, push 4'b0101, out_en=1 -> out_bit 0,1,0,1 on 4 consecutive valid cycles, out_last on 4th, chained mealy0101 flags detection.
REQ-035 Push 4'b0101 then 4'b0011 back-to-back -> 8 consecutive out_valid cycles, bits 0,1,0,1,0,0,1,1, no gap, out_last on cycles 4 and 8.
REQ-036 out_en=0, push 3 words -> in_ready low after 2nd buffered word with shifter loaded; 3rd held until pop; all three emitted in order.
REQ-037 out_en=0 for 3 cycles after 2nd bit of 4'b1010 -> out_bit stays 0, out_valid 1, then resumes 1,0.
REQ-038 Assert rst during 3rd bit with one word buffered -> outputs 0 immediately, busy=0, no remaining bits emitted.
REQ-039 MSB_FIRST=0, push 4'b0001 -> out_bit 1,0,0,0.
